// File: rtl/reg_bank32_pkg.sv
// ----------------------------------------------------------------------------
// reg_bank32_pkg
// Definitions shared by the register bank, the decode stage and the read
// multiplexers: the register-address width, the register count, the address
// type and a one-hot address decoder.
// Optional feature: REG_BANK32_BYPASS_EN (see reg_bank32.sv).
// ----------------------------------------------------------------------------
package reg_bank32_pkg;

    localparam int unsigned REG_ADDR_W = 5;
    localparam int unsigned NUM_REGS   = 32;

    typedef logic [REG_ADDR_W-1:0] reg_addr_t;

    // One-hot select for register 'addr' when 'en' is high.
    // Bit 0 is always cleared because register 0 is hard-wired to zero and
    // can never be written or marked pending.
    function automatic logic [NUM_REGS-1:0] addr_decode(input reg_addr_t addr,
                                                        input logic      en);
        logic [NUM_REGS-1:0] sel;
        sel       = '0;
        sel[addr] = en;
        sel[0]    = 1'b0;
        return sel;
    endfunction

endpackage : reg_bank32_pkg

// File: rtl/reg_bank32_scoreboard.sv
// ----------------------------------------------------------------------------
// reg_scoreboard
// Per-register pending-write flags and source-operand hazard detection.
//
// Ports:
//   clk      rising-edge clock
//   reset_n  asynchronous active-low reset, clears every pending flag
//   we, wa   write-back strobe/address (clears the pending flag of wa)
//   iss, ia  issue strobe/destination (sets the pending flag of ia)
//   rs, rt   source addresses of the instruction being decoded
//   busy     registered pending flags, bit i belongs to register i
//   stall    busy[rs] | busy[rt] from the registered flags
//
// Optional feature REG_BANK32_BYPASS_EN: an operand that is being written
// back in the current cycle does not stall, because its value is forwarded.
// ----------------------------------------------------------------------------
module reg_scoreboard
    import reg_bank32_pkg::*;
(
    input  logic                clk,
    input  logic                reset_n,
    input  logic                we,
    input  reg_addr_t           wa,
    input  logic                iss,
    input  reg_addr_t           ia,
    input  reg_addr_t           rs,
    input  reg_addr_t           rt,
    output logic [NUM_REGS-1:0] busy,
    output logic                stall
);

    logic [NUM_REGS-1:0] busy_q;
    logic [NUM_REGS-1:0] busy_d;
    logic [NUM_REGS-1:0] wr_sel;
    logic [NUM_REGS-1:0] iss_sel;
    logic                rs_pend;
    logic                rt_pend;

    assign wr_sel  = addr_decode(wa, we);
    assign iss_sel = addr_decode(ia, iss);

    // Set after clear: when issue and write-back hit the same register the
    // new producer wins and the flag stays set.
    assign busy_d = (busy_q & ~wr_sel) | iss_sel;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    always_comb begin
        rs_pend = busy_q[rs];
        rt_pend = busy_q[rt];
`ifdef REG_BANK32_BYPASS_EN
        // The write-back value is forwarded this cycle, so the operand is
        // satisfied -- unless a newer producer is issued to the same register.
        if (we && (rs == wa) && !(iss && (ia == wa))) begin
            rs_pend = 1'b0;
        end
        if (we && (rt == wa) && !(iss && (ia == wa))) begin
            rt_pend = 1'b0;
        end
`endif
    end

    assign busy  = busy_q;
    assign stall = rs_pend | rt_pend;

endmodule : reg_scoreboard

// File: rtl/reg_bank32.sv
// ----------------------------------------------------------------------------
// reg_bank32
// 32-entry register bank with a pending-write scoreboard. Register 0 always
// reads as zero.
//
// Ports:
//   clk         rising-edge clock
//   reset_n     asynchronous active-low reset, clears registers and flags
//   we, wa, wd  write-back enable, address and data
//   iss, ia     issue strobe and destination address (marks it pending)
//   rs, rt      source addresses of the instruction being decoded
//   q0..q31     register contents, feeding the read multiplexers directly
//   busy        per-register pending-write flags
//   stall       source-operand hazard indication
//
// Optional feature REG_BANK32_BYPASS_EN: when defined, a write-back is driven
// onto q<wa> combinationally in the same cycle and stops stalling its
// operand. Undefined, writes become visible one cycle after the edge.
// ----------------------------------------------------------------------------
module reg_bank32
    import reg_bank32_pkg::*;
#(
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              we,
    input  logic [4:0]        wa,
    input  logic [DATA_W-1:0] wd,
    input  logic              iss,
    input  logic [4:0]        ia,
    input  logic [4:0]        rs,
    input  logic [4:0]        rt,
    output logic [DATA_W-1:0] q0,
    output logic [DATA_W-1:0] q1,
    output logic [DATA_W-1:0] q2,
    output logic [DATA_W-1:0] q3,
    output logic [DATA_W-1:0] q4,
    output logic [DATA_W-1:0] q5,
    output logic [DATA_W-1:0] q6,
    output logic [DATA_W-1:0] q7,
    output logic [DATA_W-1:0] q8,
    output logic [DATA_W-1:0] q9,
    output logic [DATA_W-1:0] q10,
    output logic [DATA_W-1:0] q11,
    output logic [DATA_W-1:0] q12,
    output logic [DATA_W-1:0] q13,
    output logic [DATA_W-1:0] q14,
    output logic [DATA_W-1:0] q15,
    output logic [DATA_W-1:0] q16,
    output logic [DATA_W-1:0] q17,
    output logic [DATA_W-1:0] q18,
    output logic [DATA_W-1:0] q19,
    output logic [DATA_W-1:0] q20,
    output logic [DATA_W-1:0] q21,
    output logic [DATA_W-1:0] q22,
    output logic [DATA_W-1:0] q23,
    output logic [DATA_W-1:0] q24,
    output logic [DATA_W-1:0] q25,
    output logic [DATA_W-1:0] q26,
    output logic [DATA_W-1:0] q27,
    output logic [DATA_W-1:0] q28,
    output logic [DATA_W-1:0] q29,
    output logic [DATA_W-1:0] q30,
    output logic [DATA_W-1:0] q31,
    output logic [31:0]       busy,
    output logic              stall
);

    logic [DATA_W-1:0]   regs   [NUM_REGS];
    logic [DATA_W-1:0]   rd_val [NUM_REGS];
    logic [NUM_REGS-1:0] wr_sel;

    assign wr_sel = addr_decode(wa, we);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else begin
            for (int unsigned i = 1; i < NUM_REGS; i++) begin
                if (wr_sel[i]) begin
                    regs[i] <= wd;
                end
            end
        end
    end

    always_comb begin
        for (int unsigned i = 0; i < NUM_REGS; i++) begin
            rd_val[i] = regs[i];
        end
`ifdef REG_BANK32_BYPASS_EN
        // Forwarding is gated by reset_n so outputs stay zero during reset.
        for (int unsigned i = 1; i < NUM_REGS; i++) begin
            if (wr_sel[i] && reset_n) begin
                rd_val[i] = wd;
            end
        end
`endif
        rd_val[0] = '0;
    end

    reg_scoreboard u_scoreboard (
        .clk     (clk),
        .reset_n (reset_n),
        .we      (we),
        .wa      (wa),
        .iss     (iss),
        .ia      (ia),
        .rs      (rs),
        .rt      (rt),
        .busy    (busy),
        .stall   (stall)
    );

    assign q0  = rd_val[0];
    assign q1  = rd_val[1];
    assign q2  = rd_val[2];
    assign q3  = rd_val[3];
    assign q4  = rd_val[4];
    assign q5  = rd_val[5];
    assign q6  = rd_val[6];
    assign q7  = rd_val[7];
    assign q8  = rd_val[8];
    assign q9  = rd_val[9];
    assign q10 = rd_val[10];
    assign q11 = rd_val[11];
    assign q12 = rd_val[12];
    assign q13 = rd_val[13];
    assign q14 = rd_val[14];
    assign q15 = rd_val[15];
    assign q16 = rd_val[16];
    assign q17 = rd_val[17];
    assign q18 = rd_val[18];
    assign q19 = rd_val[19];
    assign q20 = rd_val[20];
    assign q21 = rd_val[21];
    assign q22 = rd_val[22];
    assign q23 = rd_val[23];
    assign q24 = rd_val[24];
    assign q25 = rd_val[25];
    assign q26 = rd_val[26];
    assign q27 = rd_val[27];
    assign q28 = rd_val[28];
    assign q29 = rd_val[29];
    assign q30 = rd_val[30];
    assign q31 = rd_val[31];

endmodule : reg_bank32

// File: tb/tb_reg_bank32.sv
// ----------------------------------------------------------------------------
// tb_reg_bank32
// Self-checking bench for reg_bank32: directed scenarios followed by random
// traffic, all compared against an array-based reference model.
// Honours REG_BANK32_BYPASS_EN in the same way as the design.
// ----------------------------------------------------------------------------
module tb_reg_bank32;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic        iss;
    logic [4:0]  ia;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [31:0] q [32];
    logic [31:0] busy;
    logic        stall;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    // Reference model state
    logic [31:0] m_regs [32];
    bit          m_busy [32];

    always #5 clk = ~clk;

    reg_bank32 #(.DATA_W(32)) dut (
        .clk(clk), .reset_n(reset_n), .we(we), .wa(wa), .wd(wd),
        .iss(iss), .ia(ia), .rs(rs), .rt(rt),
        .q0(q[0]),   .q1(q[1]),   .q2(q[2]),   .q3(q[3]),
        .q4(q[4]),   .q5(q[5]),   .q6(q[6]),   .q7(q[7]),
        .q8(q[8]),   .q9(q[9]),   .q10(q[10]), .q11(q[11]),
        .q12(q[12]), .q13(q[13]), .q14(q[14]), .q15(q[15]),
        .q16(q[16]), .q17(q[17]), .q18(q[18]), .q19(q[19]),
        .q20(q[20]), .q21(q[21]), .q22(q[22]), .q23(q[23]),
        .q24(q[24]), .q25(q[25]), .q26(q[26]), .q27(q[27]),
        .q28(q[28]), .q29(q[29]), .q30(q[30]), .q31(q[31]),
        .busy(busy), .stall(stall)
    );

    task automatic check_val(input string tag, input logic [31:0] got,
                             input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < 32; i++) begin
            m_regs[i] = '0;
            m_busy[i] = 1'b0;
        end
    endtask

    // Architectural effect of one rising edge with the current inputs.
    task automatic model_edge();
        if (!reset_n) begin
            model_clear();
        end else begin
            if (we && wa != 0) m_regs[wa] = wd;
            if (we) m_busy[wa] = 1'b0;
            if (iss && ia != 0) m_busy[ia] = 1'b1;
        end
    endtask

    function automatic logic [31:0] exp_q(input int i);
`ifdef REG_BANK32_BYPASS_EN
        if (reset_n && we && i != 0 && int'(wa) == i) return wd;
`endif
        return m_regs[i];
    endfunction

    function automatic logic operand_stalls(input logic [4:0] a);
        if (!m_busy[a]) return 1'b0;
`ifdef REG_BANK32_BYPASS_EN
        if (we && a == wa && !(iss && ia == wa)) return 1'b0;
`endif
        return 1'b1;
    endfunction

    function automatic logic [31:0] exp_busy();
        logic [31:0] v;
        for (int i = 0; i < 32; i++) v[i] = m_busy[i];
        return v;
    endfunction

    task automatic check_all(input string ctx);
        for (int i = 0; i < 32; i++) begin
            check_val($sformatf("%s.q%0d", ctx, i), q[i], exp_q(i));
        end
        check_val({ctx, ".busy"}, busy, exp_busy());
        check_val({ctx, ".stall"}, {31'b0, stall},
                  {31'b0, operand_stalls(rs) | operand_stalls(rt)});
    endtask

    // Drive one cycle of inputs after the falling edge, check outputs while
    // they are stable, then advance the model at the rising edge.
    task automatic step(input string ctx, input logic s_we, input logic [4:0] s_wa,
                        input logic [31:0] s_wd, input logic s_iss,
                        input logic [4:0] s_ia, input logic [4:0] s_rs,
                        input logic [4:0] s_rt);
        @(negedge clk);
        we = s_we; wa = s_wa; wd = s_wd;
        iss = s_iss; ia = s_ia; rs = s_rs; rt = s_rt;
        #1;
        check_all(ctx);
        @(posedge clk);
        model_edge();
    endtask

    task automatic idle(input string ctx);
        step(ctx, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0, 5'd0);
    endtask

    task automatic randomize_inputs();
        we  = 1'($urandom);
        wa  = 5'($urandom);
        wd  = $urandom;
        iss = 1'($urandom);
        ia  = 5'($urandom);
        rs  = 5'($urandom);
        rt  = 5'($urandom);
    endtask

    initial begin
        model_clear();
        reset_n = 1'b0;
        randomize_inputs();

        // Reset held with random inputs: everything stays zero.
        repeat (3) begin
            @(negedge clk);
            randomize_inputs();
            #1;
            check_all("rst_hold");
            @(posedge clk);
            model_edge();
        end
        @(negedge clk);
        we = 1'b0; iss = 1'b0; wa = '0; ia = '0; rs = '0; rt = '0; wd = '0;
        reset_n = 1'b1;
        idle("rst_rel");
        idle("rst_rel2");

        // Plain write to register 5.
        step("wr5", 1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 5'd5, 5'd0);
        idle("wr5_after");
        check_val("q5_value", q[5], 32'hDEADBEEF);

        // Writes and issues to register 0 are ignored.
        step("wr0", 1'b1, 5'd0, 32'hFFFFFFFF, 1'b1, 5'd0, 5'd0, 5'd0);
        idle("wr0_after");
        check_val("q0_zero", q[0], 32'h0);
        check_val("busy0_zero", {31'b0, busy[0]}, 32'h0);

        // Issue 7, read it, then write it back.
        step("iss7", 1'b0, 5'd0, 32'h0, 1'b1, 5'd7, 5'd0, 5'd0);
        step("rd7", 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd7, 5'd0);
        step("wb7", 1'b1, 5'd7, 32'h0000_0777, 1'b0, 5'd0, 5'd7, 5'd0);
        step("rd7_after", 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd7, 5'd0);
        check_val("busy7_clear", {31'b0, busy[7]}, 32'h0);
        check_val("stall7_clear", {31'b0, stall}, 32'h0);

        // Issue and write-back to 9 in the same cycle: new producer wins.
        step("iss_wb9", 1'b1, 5'd9, 32'h0000_1234, 1'b1, 5'd9, 5'd9, 5'd9);
        idle("iss_wb9_after");
        check_val("q9_value", q[9], 32'h0000_1234);
        check_val("busy9_set", {31'b0, busy[9]}, 32'h1);

        // Issue and write-back to different registers in the same cycle.
        step("iss4_wb9", 1'b1, 5'd9, 32'h0000_5678, 1'b1, 5'd4, 5'd4, 5'd9);
        idle("iss4_wb9_after");

        // Load register 3, then reset mid-cycle while writing it again.
        step("wr3", 1'b1, 5'd3, 32'hCAFE_F00D, 1'b1, 5'd12, 5'd0, 5'd0);
        idle("wr3_after");
        @(negedge clk);
        we = 1'b1; wa = 5'd3; wd = 32'h1111_2222; iss = 1'b1; ia = 5'd3;
        rs = 5'd12; rt = 5'd3;
        #2;
        reset_n = 1'b0;
        model_clear();
        #1;
        check_val("async_q3", q[3], 32'h0);
        check_val("async_busy", busy, 32'h0);
        check_val("async_stall", {31'b0, stall}, 32'h0);
        check_all("async_rst");
        @(posedge clk);
        model_edge();
        @(negedge clk);
        #1;
        check_all("async_rst_edge");
        we = 1'b0; iss = 1'b0;
        reset_n = 1'b1;
        idle("async_rel");

        // Random traffic, biased toward a few registers to create hazards.
        for (int n = 0; n < 400; n++) begin
            logic [4:0] a_wa, a_ia, a_rs, a_rt;
            a_wa = ($urandom_range(0, 1) != 0) ? 5'($urandom_range(0, 7)) : 5'($urandom);
            a_ia = ($urandom_range(0, 1) != 0) ? 5'($urandom_range(0, 7)) : 5'($urandom);
            a_rs = 5'($urandom_range(0, 7));
            a_rt = 5'($urandom);
            step("rand", 1'($urandom), a_wa, $urandom, 1'($urandom), a_ia, a_rs, a_rt);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_reg_bank32

// File: doc/reg_bank32.md
REG_BANK32 -- requirements
Module: reg_bank32

Interface
REQ-001 Parameter DATA_W, default 32, register data width; SHALL be the only width parameter.
REQ-002 Ports (clock and reset first): clk input 1, rising-edge clock.
REQ-003 reset_n input 1, reset; asynchronous, active-low.
REQ-004 we input 1, write-back enable.
REQ-005 wa input 5, write-back register address.
REQ-006 wd input DATA_W, write-back data.
REQ-007 iss input 1, issue strobe; marks the destination register as pending.
REQ-008 ia input 5, issue destination address.
REQ-009 rs, rt inputs 5 each, source addresses of the instruction being decoded.
REQ-010 q0..q31 outputs DATA_W each, register contents; feed the 32:1 read multiplexers directly.
REQ-011 busy output 32, per-register pending-write flags; bit i corresponds to register i.
REQ-012 stall output 1, source-operand hazard indication.

Function
REQ-013 The block SHALL hold 32 registers; register 0 SHALL read as 0 at all times.
REQ-014 On a clk rising edge with we=1 and wa!=0, register wa SHALL load wd; the new value SHALL appear on q<wa> one cycle later (base build).
REQ-015 A write with wa=0 SHALL change no state.
REQ-016 On a clk rising edge with iss=1 and ia!=0, busy[ia] SHALL be set to 1.
REQ-017 On a clk rising edge with we=1, busy[wa] SHALL be cleared unless REQ-018 applies.
REQ-018 Simultaneous iss=1 and we=1 with ia==wa: the register SHALL load wd and busy[ia] SHALL remain 1, because the new producer wins.
REQ-019 Simultaneous iss and we to different registers SHALL both take effect in the same cycle.
REQ-020 busy[0] SHALL be 0 at all times; iss with ia=0 SHALL be ignored.
REQ-021 stall SHALL be combinational: busy[rs] OR busy[rt], using the registered busy value.
REQ-022 stall SHALL not be masked by a same-cycle we to rs/rt in the base build.
REQ-023 Arithmetic: no width conversion; wd SHALL be stored bit-exact.

Reset
REQ-024 reset_n=0 SHALL asynchronously clear all registers and all busy bits to 0.
REQ-025 While reset_n=0, outputs SHALL be: q*=0, busy=0, stall=0.
REQ-026 Writes and issues presented during reset SHALL be discarded.
REQ-027 Release of reset SHALL take effect at the next rising edge with no other state change.

Configuration
REQ-028 Macro REG_BANK32_BYPASS_EN: when defined, a write with we=1 and wa!=0 SHALL drive wd onto q<wa> combinationally in the same cycle.
REQ-029 With REG_BANK32_BYPASS_EN defined, stall SHALL exclude any operand whose address equals wa while we=1, unless REQ-018 applies.
REQ-030 Without REG_BANK32_BYPASS_EN, REQ-014 and REQ-022 latency SHALL hold unchanged.

Structure
REQ-031 A shared package SHALL hold the following, for reuse by the decode stage and the read multiplexers:
- REG_ADDR_W=5
- NUM_REGS=32
- the reg_addr_t typedef
REQ-032 One sub-module, reg_scoreboard, SHALL contain the busy flags and stall logic; the data array SHALL remain in reg_bank32.

Verification
REQ-033 Reset with all inputs random, then release -> q0..q31=0, busy=0, stall=0.
REQ-034 Write we=1, wa=5, wd=0xDEADBEEF -> q5=0xDEADBEEF on the next cycle (same cycle with BYPASS_EN); all other q unchanged.
REQ-035 Write we=1, wa=0, wd=0xFFFFFFFF -> q0 stays 0. Issue iss=1, ia=0 -> busy[0] stays 0.
REQ-036 Issue ia=7, then rs=7 -> stall=1. Write-back wa=7 -> busy[7]=0 and stall=0 on the next cycle.
REQ-037 Issue ia=9 and write wa=9, wd=0x1234 in the same cycle -> q9=0x1234 and busy[9]=1.
REQ-038 Assert reset_n=0 mid-cycle while we=1, wa=3 -> q3=0 and busy=0 immediately, with no clock edge required.
